vt_esc_parser: RTL and testbench

Byte-stream decoder between `uart_rx` and the framebuffer character writer of the WT-220 terminal. It accepts raw received bytes and classifies printable characters and C0 controls. It also parses a VT100/ANSI CSI subset (cursor position, relative move, erase display, erase line). Each decoded action is emitted as one registered command word over a valid/ready handshake. The writer then applies the command to cursor and framebuffer state.

---
 rtl/vt_esc_parser.sv | 207 ++++++++++++++++++++
 tb/tb_vt_esc_parser.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vt_esc_parser.sv
`default_nettype none
// ============================================================================
// Module   : vt_esc_parser
// Brief    : Byte-stream decoder for printable chars, C0 controls and a small
//            VT100/ANSI CSI subset; emits one registered command per action.
// Revision : 1.0 - initial release
// ============================================================================
module vt_esc_parser #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] cmd_op,
    output logic [7:0] cmd_char,
    output logic [6:0] cmd_arg0,
    output logic [6:0] cmd_arg1
);

    localparam logic [2:0] c_OP_PUT    = 3'd0;
    localparam logic [2:0] c_OP_CR     = 3'd1;
    localparam logic [2:0] c_OP_LF     = 3'd2;
    localparam logic [2:0] c_OP_BS     = 3'd3;
    localparam logic [2:0] c_OP_SETPOS = 3'd4;
    localparam logic [2:0] c_OP_MOVE   = 3'd5;
    localparam logic [2:0] c_OP_ED     = 3'd6;
    localparam logic [2:0] c_OP_EL     = 3'd7;

    localparam logic [6:0] c_ROW_MAX = 7'(ROWS - 1);
    localparam logic [6:0] c_COL_MAX = 7'(COLS - 1);

    typedef enum logic [1:0] {
        S_GROUND = 2'd0,
        S_ESC    = 2'd1,
        S_CSI    = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] p0_q, p0_d;
    logic [6:0] p1_q, p1_d;
    logic [1:0] idx_q, idx_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [2:0] op_q, op_d;
    logic [7:0] char_q, char_d;
    logic [6:0] arg0_q, arg0_d;
    logic [6:0] arg1_q, arg1_d;

    logic        accept;
    logic        emit;
    logic [2:0]  e_op;
    logic [7:0]  e_char;
    logic [6:0]  e_arg0;
    logic [6:0]  e_arg1;
    logic [6:0]  p_sel;
    logic [10:0] prod;
    logic [6:0]  p_sat;
    logic [6:0]  row_raw;
    logic [6:0]  col_raw;
    logic [6:0]  row_clamp;
    logic [6:0]  col_clamp;

    assign in_ready  = !cmd_valid_q && resetn;
    assign accept    = in_valid && in_ready;
    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = op_q;
    assign cmd_char  = char_q;
    assign cmd_arg0  = arg0_q;
    assign cmd_arg1  = arg1_q;

    // Parameter accumulation: widen before multiply so 127*10+9 cannot wrap.
    always_comb begin
        p_sel     = (idx_q == 2'd0) ? p0_q : p1_q;
        prod      = ({4'd0, p_sel} * 11'd10) + {7'd0, in_data[3:0]};
        p_sat     = (prod > 11'd127) ? 7'd127 : prod[6:0];
        row_raw   = (p0_q == 7'd0) ? 7'd0 : p0_q - 7'd1;
        col_raw   = (p1_q == 7'd0) ? 7'd0 : p1_q - 7'd1;
        row_clamp = (row_raw > c_ROW_MAX) ? c_ROW_MAX : row_raw;
        col_clamp = (col_raw > c_COL_MAX) ? c_COL_MAX : col_raw;
    end

    always_comb begin
        state_d     = state_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        idx_d       = idx_q;
        cmd_valid_d = cmd_valid_q && !cmd_ready;
        op_d        = op_q;
        char_d      = char_q;
        arg0_d      = arg0_q;
        arg1_d      = arg1_q;
        emit        = 1'b0;
        e_op        = 3'd0;
        e_char      = 8'd0;
        e_arg0      = 7'd0;
        e_arg1      = 7'd0;

        if (accept) begin
            if (in_data == 8'h18 || in_data == 8'h1A) begin
                state_d = S_GROUND;
            end else begin
                case (state_q)
                    S_GROUND: begin
                        if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                            emit   = 1'b1;
                            e_op   = c_OP_PUT;
                            e_char = in_data;
                        end else if (in_data == 8'h0D) begin
                            emit = 1'b1;
                            e_op = c_OP_CR;
                        end else if (in_data == 8'h0A) begin
                            emit = 1'b1;
                            e_op = c_OP_LF;
                        end else if (in_data == 8'h08) begin
                            emit = 1'b1;
                            e_op = c_OP_BS;
                        end else if (in_data == 8'h1B) begin
                            state_d = S_ESC;
                        end
                    end
                    S_ESC: begin
                        if (in_data == 8'h5B) begin
                            state_d = S_CSI;
                            p0_d    = 7'd0;
                            p1_d    = 7'd0;
                            idx_d   = 2'd0;
                        end else if (in_data != 8'h1B) begin
                            state_d = S_GROUND;
                        end
                    end
                    S_CSI: begin
                        // Anything not recognised below aborts silently.
                        state_d = S_GROUND;
                        if (in_data >= 8'h30 && in_data <= 8'h39) begin
                            state_d = S_CSI;
                            if (idx_q == 2'd0) begin
                                p0_d = p_sat;
                            end else if (idx_q == 2'd1) begin
                                p1_d = p_sat;
                            end
                        end else if (in_data == 8'h3B) begin
                            state_d = S_CSI;
                            if (idx_q != 2'd2) begin
                                idx_d = idx_q + 2'd1;
                            end
                        end else if (in_data == 8'h48 || in_data == 8'h66) begin
                            emit   = 1'b1;
                            e_op   = c_OP_SETPOS;
                            e_arg0 = row_clamp;
                            e_arg1 = col_clamp;
                        end else if (in_data >= 8'h41 && in_data <= 8'h44) begin
                            emit   = 1'b1;
                            e_op   = c_OP_MOVE;
                            e_char = in_data;
                            e_arg0 = (p0_q == 7'd0) ? 7'd1 : p0_q;
                        end else if (in_data == 8'h4A || in_data == 8'h4B) begin
                            emit   = (p0_q <= 7'd2);
                            e_op   = (in_data == 8'h4A) ? c_OP_ED : c_OP_EL;
                            e_arg0 = p0_q;
                        end else if (in_data == 8'h1B) begin
                            state_d = S_ESC;
                        end
                    end
                    default: state_d = S_GROUND;
                endcase
            end
        end

        if (emit) begin
            cmd_valid_d = 1'b1;
            op_d        = e_op;
            char_d      = e_char;
            arg0_d      = e_arg0;
            arg1_d      = e_arg1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_GROUND;
            p0_q        <= 7'd0;
            p1_q        <= 7'd0;
            idx_q       <= 2'd0;
            cmd_valid_q <= 1'b0;
            op_q        <= 3'd0;
            char_q      <= 8'd0;
            arg0_q      <= 7'd0;
            arg1_q      <= 7'd0;
        end else begin
            state_q     <= state_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            idx_q       <= idx_d;
            cmd_valid_q <= cmd_valid_d;
            op_q        <= op_d;
            char_q      <= char_d;
            arg0_q      <= arg0_d;
            arg1_q      <= arg1_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vt_esc_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_vt_esc_parser
// Brief    : Scoreboard bench for vt_esc_parser using directed byte sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vt_esc_parser;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       in_ready;
    logic       cmd_valid;
    logic [2:0] cmd_op;
    logic [7:0] cmd_char;
    logic [6:0] cmd_arg0;
    logic [6:0] cmd_arg1;

    int checks = 0;
    int failures = 0;
    logic [24:0] sb[$];

    vt_esc_parser #(.COLS(80), .ROWS(30)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_char  (cmd_char),
        .cmd_arg0  (cmd_arg0),
        .cmd_arg1  (cmd_arg1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_cmd(input logic [2:0] op, input logic [7:0] ch,
                              input logic [6:0] a0, input logic [6:0] a1);
        sb.push_back({op, ch, a0, a1});
    endtask

    // Monitor: one pop per handshake, independent of the stimulus process.
    always @(negedge clk) begin
        if (resetn && cmd_valid && cmd_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_cmd: actual op=%0d char=%0h a0=%0d a1=%0d required=none",
                         cmd_op, cmd_char, cmd_arg0, cmd_arg1);
            end else begin
                chk("cmd_word", {7'd0, cmd_op, cmd_char, cmd_arg0, cmd_arg1}, {7'd0, sb.pop_front()});
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit ec);
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: actual=not accepted required=accepted byte=%0h", b);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (ec) begin
            @(negedge clk);
            chk("latency_valid", {31'd0, cmd_valid}, 32'd1);
        end
    endtask

    task automatic send_csi(input string s, input bit ec);
        send(8'h1B, 1'b0);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], ec && (i == s.len() - 1));
        end
    endtask

    task automatic reset_check();
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_cmd_op",    {29'd0, cmd_op},    32'd0);
        chk("rst_cmd_char",  {24'd0, cmd_char},  32'd0);
        chk("rst_cmd_arg0",  {25'd0, cmd_arg0},  32'd0);
        chk("rst_cmd_arg1",  {25'd0, cmd_arg1},  32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        reset_check();

        // Printable text and C0 controls
        expect_cmd(3'd0, 8'h48, 7'd0, 7'd0); send(8'h48, 1'b1);
        expect_cmd(3'd0, 8'h69, 7'd0, 7'd0); send(8'h69, 1'b1);
        expect_cmd(3'd1, 8'h00, 7'd0, 7'd0); send(8'h0D, 1'b1);
        expect_cmd(3'd2, 8'h00, 7'd0, 7'd0); send(8'h0A, 1'b1);
        send(8'h07, 1'b0);
        send(8'h7F, 1'b0);
        send(8'hC3, 1'b0);
        expect_cmd(3'd3, 8'h00, 7'd0, 7'd0); send(8'h08, 1'b1);

        // Cursor positioning, including saturation then clamping
        expect_cmd(3'd4, 8'h00, 7'd11, 7'd39); send_csi("[12;40H", 1'b1);
        expect_cmd(3'd4, 8'h00, 7'd0,  7'd0);  send_csi("[H", 1'b1);
        expect_cmd(3'd4, 8'h00, 7'd29, 7'd79); send_csi("[99;200H", 1'b1);
        expect_cmd(3'd4, 8'h00, 7'd4,  7'd6);  send_csi("[5;7f", 1'b1);

        // Relative moves and erases; mode 3 produces nothing
        expect_cmd(3'd5, 8'h41, 7'd1, 7'd0); send_csi("[A", 1'b1);
        expect_cmd(3'd5, 8'h43, 7'd5, 7'd0); send_csi("[5C", 1'b1);
        expect_cmd(3'd5, 8'h44, 7'd127, 7'd0); send_csi("[300D", 1'b1);
        expect_cmd(3'd6, 8'h00, 7'd2, 7'd0); send_csi("[2J", 1'b1);
        expect_cmd(3'd7, 8'h00, 7'd0, 7'd0); send_csi("[K", 1'b1);
        send_csi("[3J", 1'b0);

        // Back-pressure: word held, in_ready low, next byte waits
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        expect_cmd(3'd0, 8'h78, 7'd0, 7'd0);
        expect_cmd(3'd0, 8'h79, 7'd0, 7'd0);
        send(8'h78, 1'b1);
        in_data  = 8'h79;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, cmd_valid}, 32'd1);
            chk("stall_word", {7'd0, cmd_op, cmd_char, cmd_arg0, cmd_arg1},
                {7'd0, 3'd0, 8'h78, 7'd0, 7'd0});
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("y_accepted_valid", {31'd0, cmd_valid}, 32'd1);

        // Extra params ignored, CAN abort, ESC restarting a sequence
        expect_cmd(3'd4, 8'h00, 7'd0, 7'd1); send_csi("[1;2;3H", 1'b1);
        send_csi("[5", 1'b0);
        send(8'h18, 1'b0);
        expect_cmd(3'd0, 8'h61, 7'd0, 7'd0); send(8'h61, 1'b1);
        send_csi("[5", 1'b0);
        expect_cmd(3'd7, 8'h00, 7'd2, 7'd0); send_csi("[2K", 1'b1);
        send_csi("[4", 1'b0);
        send(8'h1A, 1'b0);
        expect_cmd(3'd0, 8'h42, 7'd0, 7'd0); send(8'h42, 1'b1);

        // Reset mid-sequence discards the partial CSI
        send_csi("[3", 1'b0);
        reset_check();
        expect_cmd(3'd0, 8'h41, 7'd0, 7'd0); send(8'h41, 1'b1);

        repeat (10) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
